// File: rtl/race_pkg.sv
// Shared race definitions: game FSM state codes, lap tracker encoding,
// winner codes and the zone box compare.
package race_pkg;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTING   = 3'd1;
    localparam logic [2:0] COUNTDOWN = 3'd3;
    localparam logic [2:0] RACING    = 3'd4;
    localparam logic [2:0] PAUSE     = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    typedef enum logic [1:0] {
        WAIT_CP = 2'd0,
        ARMED   = 2'd1,
        DONE    = 2'd2
    } trk_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Inclusive unsigned box test; bounds arrive as operands so a zero
    // lower bound does not collapse into a constant compare.
    function automatic logic in_box(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [9:0] x0,
        input logic [9:0] x1,
        input logic [9:0] y0,
        input logic [9:0] y1
    );
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

endpackage

// File: rtl/lap_tracker_if.sv
// Bundle between the game side (positions, state) and the lap tracker
// (laps, times, result).
interface lap_tracker_if;
    logic [2:0]  state;
    logic [9:0]  p1_pos_x;
    logic [9:0]  p1_pos_y;
    logic [9:0]  p2_pos_x;
    logic [9:0]  p2_pos_y;
    logic [1:0]  p1_lap;
    logic [1:0]  p2_lap;
    logic [15:0] race_time;
    logic [15:0] p1_time;
    logic [15:0] p2_time;
    logic [1:0]  winner;
    logic        is_game_end;

    modport master (
        output state, p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y,
        input  p1_lap, p2_lap, race_time, p1_time, p2_time, winner, is_game_end
    );

    modport slave (
        input  state, p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y,
        output p1_lap, p2_lap, race_time, p1_time, p2_time, winner, is_game_end
    );
endinterface

// File: rtl/lap_player_tracker.sv
// One player's lap validation: checkpoint must be entered before a finish
// entry counts; latches the race time when the last lap completes.
module lap_player_tracker
    import race_pkg::*;
#(
    parameter int LAPS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        in_fin,
    input  logic        in_cp,
    input  logic [15:0] race_time,
    output logic [1:0]  lap,
    output logic        done_pulse,
    output logic [15:0] finish_time,
    output logic        done
);

    trk_state_t  state_reg;
    logic [1:0]  lap_reg;
    logic [15:0] time_reg;
    logic        prev_fin_reg;
    logic        prev_cp_reg;

    logic        fin_entry;
    logic        cp_entry;
    logic [1:0]  lap_next;
    logic        lap_full;

    assign fin_entry = in_fin & ~prev_fin_reg;
    assign cp_entry  = in_cp & ~prev_cp_reg;
    assign lap_next  = lap_reg + 2'd1;
    assign lap_full  = (lap_next == 2'(LAPS));

    // A simultaneous checkpoint entry wins over the finish entry.
    assign done_pulse = enable && (state_reg == ARMED) && fin_entry && !cp_entry && lap_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= WAIT_CP;
            lap_reg      <= 2'd0;
            time_reg     <= 16'd0;
            prev_fin_reg <= 1'b0;
            prev_cp_reg  <= 1'b0;
        end else begin
            // Edge history runs in every state so parked cars never re-trigger.
            prev_fin_reg <= in_fin;
            prev_cp_reg  <= in_cp;
            if (clear) begin
                state_reg <= WAIT_CP;
                lap_reg   <= 2'd0;
                time_reg  <= 16'd0;
            end else if (enable) begin
                case (state_reg)
                    WAIT_CP: begin
                        if (cp_entry) state_reg <= ARMED;
                    end
                    ARMED: begin
                        if (fin_entry && !cp_entry) begin
                            lap_reg <= lap_next;
                            if (lap_full) begin
                                state_reg <= DONE;
                                time_reg  <= race_time;
                            end else begin
                                state_reg <= WAIT_CP;
                            end
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

    assign lap         = lap_reg;
    assign finish_time = time_reg;
    assign done        = (state_reg == DONE);

endmodule

// File: rtl/lap_tracker.sv
// Race progress: two lap trackers, centisecond race clock and end-of-race
// detection with winner decode.
module lap_tracker
    import race_pkg::*;
#(
    parameter int LAPS     = 3,
    parameter int TICK_DIV = 1_000_000,
    parameter int FIN_X0   = 0,
    parameter int FIN_X1   = 40,
    parameter int FIN_Y0   = 118,
    parameter int FIN_Y1   = 122,
    parameter int CP_X0    = 280,
    parameter int CP_X1    = 319,
    parameter int CP_Y0    = 110,
    parameter int CP_Y1    = 130
) (
    input  logic          clk,
    input  logic          rst,
    lap_tracker_if.slave  bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;
    logic [15:0]   race_time_reg;
    logic [1:0]    winner_reg;
    logic          game_end_reg;

    logic          clear;
    logic          enable;
    logic [9:0]    pos_x [2];
    logic [9:0]    pos_y [2];
    logic [1:0]    in_fin;
    logic [1:0]    in_cp;
    logic [1:0]    lap [2];
    logic [15:0]   finish_time [2];
    logic [1:0]    done_pulse;
    logic [1:0]    done;
    logic [1:0]    newly_done;

    assign clear  = (bus.state == IDLE) || (bus.state == SETTING);
    assign enable = (bus.state == RACING) && !game_end_reg;

    assign pos_x[0] = bus.p1_pos_x;
    assign pos_y[0] = bus.p1_pos_y;
    assign pos_x[1] = bus.p2_pos_x;
    assign pos_y[1] = bus.p2_pos_y;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_player
            assign in_fin[gi] = in_box(pos_x[gi], pos_y[gi], 10'(FIN_X0), 10'(FIN_X1),
                                       10'(FIN_Y0), 10'(FIN_Y1));
            assign in_cp[gi]  = in_box(pos_x[gi], pos_y[gi], 10'(CP_X0), 10'(CP_X1),
                                       10'(CP_Y0), 10'(CP_Y1));

            lap_player_tracker #(.LAPS(LAPS)) u_trk (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear),
                .enable      (enable),
                .in_fin      (in_fin[gi]),
                .in_cp       (in_cp[gi]),
                .race_time   (race_time_reg),
                .lap         (lap[gi]),
                .done_pulse  (done_pulse[gi]),
                .finish_time (finish_time[gi]),
                .done        (done[gi])
            );
        end
    endgenerate

    assign newly_done = done_pulse & ~done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg     <= '0;
            race_time_reg <= 16'd0;
            winner_reg    <= WIN_NONE;
            game_end_reg  <= 1'b0;
        end else if (clear) begin
            presc_reg     <= '0;
            race_time_reg <= 16'd0;
            winner_reg    <= WIN_NONE;
            game_end_reg  <= 1'b0;
        end else if (enable) begin
            if (presc_reg == PRESC_MAX) begin
                presc_reg <= '0;
                if (race_time_reg != 16'hFFFF) race_time_reg <= race_time_reg + 16'd1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            // Both bits set on the same edge encodes a tie.
            if (|newly_done) begin
                game_end_reg <= 1'b1;
                winner_reg   <= {newly_done[1], newly_done[0]};
            end
        end
    end

    assign bus.p1_lap      = lap[0];
    assign bus.p2_lap      = lap[1];
    assign bus.p1_time     = finish_time[0];
    assign bus.p2_time     = finish_time[1];
    assign bus.race_time   = race_time_reg;
    assign bus.winner      = winner_reg;
    assign bus.is_game_end = game_end_reg;

endmodule
